// File: rtl/dmem_pkg.sv
// Shared widths and the store-buffer entry payload for the data-memory responder.
package dmem_pkg;
  localparam int unsigned WORD_W    = 32;
  localparam int unsigned BYTE_OFF  = 2;
  localparam int unsigned IDX_MAX_W = WORD_W - BYTE_OFF;

  // Index field is sized for the widest word index; modules zero-extend their own index into it.
  typedef struct packed {
    logic                 valid;
    logic [IDX_MAX_W-1:0] index;
    logic [WORD_W-1:0]    data;
  } sb_entry_t;
endpackage

// File: rtl/store_fifo.sv
// Store-buffer FIFO: entry array, pointers, occupancy, enqueue/drain control and youngest-match forwarding.
module store_fifo
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IDX_W = 6
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_mem_write,
  input  logic                         i_mem_read,
  input  logic [IDX_W-1:0]             i_idx,
  input  logic [WORD_W-1:0]            i_data,
  output logic                         o_drain_c,
  output logic                         o_full_c,
  output logic                         o_empty_c,
  output logic [IDX_W-1:0]             o_drain_idx_c,
  output logic [WORD_W-1:0]            o_drain_data_c,
  output logic                         o_hit_c,
  output logic [WORD_W-1:0]            o_hit_data_c,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);
  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned COUNT_W = $clog2(DEPTH+1);

  sb_entry_t          r_entries [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [COUNT_W-1:0] r_count;

  logic               w_drain;
  logic               w_enq;
  logic               w_full;
  logic               w_empty;
  logic [PTR_W-1:0]   w_slot;
  logic               w_hit;
  logic [WORD_W-1:0]  w_hit_data;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == COUNT_W'(DEPTH));
  assign w_drain = !w_empty && !i_mem_read;
  assign w_enq   = i_mem_write && (!w_full || w_drain);

  // Drain clears valid before enqueue writes so a same-slot enqueue on a full buffer wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
    end else begin
      if (w_drain) begin
        r_entries[r_rd_ptr].valid <= 1'b0;
        r_rd_ptr                  <= r_rd_ptr + PTR_W'(1);
      end
      if (w_enq) begin
        r_entries[r_wr_ptr] <= '{valid: 1'b1, index: IDX_MAX_W'(i_idx), data: i_data};
        r_wr_ptr            <= r_wr_ptr + PTR_W'(1);
      end
      if (w_enq && !w_drain) begin
        r_count <= r_count + COUNT_W'(1);
      end else if (!w_enq && w_drain) begin
        r_count <= r_count - COUNT_W'(1);
      end
    end
  end

  // Walk oldest to youngest so the last match found is the youngest.
  always_comb begin
    w_hit      = 1'b0;
    w_hit_data = '0;
    w_slot     = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      w_slot = r_rd_ptr + PTR_W'(i);
      if (r_entries[w_slot].valid && (r_entries[w_slot].index == IDX_MAX_W'(i_idx))) begin
        w_hit      = 1'b1;
        w_hit_data = r_entries[w_slot].data;
      end
    end
  end

  assign o_drain_c      = w_drain;
  assign o_full_c       = w_full;
  assign o_empty_c      = w_empty;
  assign o_drain_idx_c  = IDX_W'(r_entries[r_rd_ptr].index);
  assign o_drain_data_c = r_entries[r_rd_ptr].data;
  assign o_hit_c        = w_hit;
  assign o_hit_data_c   = w_hit_data;
  assign o_count        = r_count;
endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory responder: buffered stores drained into a word RAM on non-load cycles, forwarding loads.
module dmem_store_buffer
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned MEM_WORDS = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       MemWrite,
  input  logic                       MemRead,
  input  logic [31:0]                DataAdr,
  input  logic [31:0]                WriteData,
  output logic [31:0]                ReadData,
  output logic                       Stall,
  output logic                       Empty,
  output logic [$clog2(DEPTH+1)-1:0] Count
);
  localparam int unsigned IDX_W = $clog2(MEM_WORDS);

  logic [WORD_W-1:0] r_mem [MEM_WORDS];

  logic [IDX_W-1:0]  w_idx;
  logic              w_drain;
  logic              w_full;
  logic [IDX_W-1:0]  w_drain_idx;
  logic [WORD_W-1:0] w_drain_data;
  logic              w_hit;
  logic [WORD_W-1:0] w_hit_data;
  logic              w_unused_adr;

  // Upper address bits wrap onto the RAM; the byte offset is assumed zero.
  assign w_idx        = DataAdr[IDX_W+BYTE_OFF-1:BYTE_OFF];
  assign w_unused_adr = ^{DataAdr[WORD_W-1:IDX_W+BYTE_OFF], DataAdr[BYTE_OFF-1:0]};

  store_fifo #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_store_fifo (
    .clk            (clk),
    .rst_n          (reset),
    .i_mem_write    (MemWrite),
    .i_mem_read     (MemRead),
    .i_idx          (w_idx),
    .i_data         (WriteData),
    .o_drain_c      (w_drain),
    .o_full_c       (w_full),
    .o_empty_c      (Empty),
    .o_drain_idx_c  (w_drain_idx),
    .o_drain_data_c (w_drain_data),
    .o_hit_c        (w_hit),
    .o_hit_data_c   (w_hit_data),
    .o_count        (Count)
  );

  // RAM contents survive reset.
  always_ff @(posedge clk) begin
    if (w_drain) begin
      r_mem[w_drain_idx] <= w_drain_data;
    end
  end

  assign ReadData = w_hit ? w_hit_data : r_mem[w_idx];
  assign Stall    = MemWrite && w_full && !w_drain;
endmodule

// File: doc/dmem_store_buffer.md
Name: dmem_store_buffer

Overview:
Data-memory responder on the processor's MemWrite/DataAdr/WriteData/ReadData port; the memory-side end of the store interface the processor drives.
- Stores are accepted into a small FIFO store buffer and drained into a single-port word RAM on cycles when no load needs the port.
- Loads read combinationally. The youngest matching buffered store is forwarded ahead of RAM contents.
- Sits between the pipelined core's Memory stage and the data RAM. Stall feeds the hazard unit.

Parameters:
DEPTH, 4, store-buffer entries (power of two, >=2)
MEM_WORDS, 64, RAM size in 32-bit words (power of two)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  store request this cycle
MemRead  input  1  load request this cycle; owns the RAM port
DataAdr  input  32  byte address, word-aligned; word index = DataAdr[$clog2(MEM_WORDS)+1:2], upper bits ignored (wrap)
WriteData  input  32  store data
ReadData  output  32  load data, combinational
Stall  output  1  store not accepted this cycle; core must hold it
Empty  output  1  buffer holds no entries
Count  output  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, async): wr_ptr=rd_ptr=Count=0, Empty=1, Stall=0, entry valid bits cleared.
  - Buffered stores are discarded, including any reset mid-operation.
  - RAM contents are not reset and keep prior values.
- Drain condition: drain = !Empty && !MemRead.
  - On drain, the oldest entry is written to RAM at the clock edge and rd_ptr advances.
  - At most one drain per cycle.
- Enqueue condition: enq = MemWrite && (Count<DEPTH || drain).
  - A full buffer accepts a store in the same cycle it drains.
- Stall = MemWrite && (Count==DEPTH) && !drain. This is combinational, same cycle.
  - A stalled store is not enqueued; the core re-presents it.
- Simultaneous enq and drain: Count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. Count is the sole full/empty indicator.
- ReadData:
  - Index match against all valid entries; the youngest match (nearest wr_ptr-1) wins.
  - If no entry matches, RAM[index] is returned.
  - A store presented in the same cycle is not visible to a load in that cycle.
  - When MemRead=0, ReadData still reflects DataAdr (don't-care to the core).
- Order: stores reach RAM in acceptance order. Two stores to one address leave the later value.
- Latency:
  - Store visible to loads via forwarding from the next cycle.
  - Store reaches RAM after Count-ahead drains plus cycles where MemRead=1.
- Starvation: continuous MemRead blocks draining. The buffer fills, then Stall asserts. This is accepted behaviour; the core always has non-load cycles.

Decomposition:
- Package dmem_pkg: WORD_W=32, BYTE_OFF=2, and typedef sb_entry_t {logic valid; logic [idx] index; logic [31:0] data}. The idx width is parameterized in the module.
- Sub-module store_fifo holds the entry array, pointers, Count, enq/drain, and the forwarding-match logic (outputs hit, hit_data).
- The top holds the RAM, Stall, and the ReadData mux.

Test Plan:
- Forwarding: reset; store 7 to 100 with MemRead=1 throughout; next cycle load 100 -> ReadData=7, Count=1. Drop MemRead one cycle -> Empty=1; load 100 -> 7 from RAM.
- Full and stall:
  - Hold MemRead=1; store 1,2,3,4 to 0,4,8,12 -> Count=4.
  - Store 5 to 16 -> Stall=1, Count stays 4.
  - Drop MemRead that cycle -> Stall=0, store accepted, Count stays 4.
- Youngest wins: store 3 then 5 to 96 with MemRead=1; load 96 -> 5. Drain all; load 96 -> 5.
- Reset mid-operation:
  - Preload RAM[40]=9 and drain.
  - Buffer 3 stores including 11 to 40, then pulse reset low asynchronously between edges.
  - Expect Count=0, Empty=1, Stall=0, and load 40 -> 9.
- Pointer wrap: 10 stores of values 10..19 to 0..36, interleaving MemRead so drain and enqueue overlap. Final loads return 10..19, Count never exceeds 4.
- Address aliasing: with MEM_WORDS=64, store 7 to 256+100 -> load 100 returns 7.
